// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encodings and decode helpers shared by the ALU and the decoder.
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_EQ   = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIVU = 4'd11;
  localparam logic [3:0] ALU_XOR  = 4'd12;
  localparam logic [3:0] ALU_REMU = 4'd13;
  function automatic logic is_iterative(input logic [3:0] op);
    return op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU;
  endfunction
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: bit-serial MUL (MSB-first shift-add) and restoring DIVU/REMU, one step per cycle.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] p, q, d, p_n, q_n;
  logic [SHW-1:0] cnt;
  logic [3:0] op_q;
  logic [WIDTH:0] r;
  logic ge;
  // p is the product accumulator or partial remainder; q is the multiplier or dividend/quotient.
  // A zero divisor always passes the compare, giving an all-ones quotient and remainder == a.
  always_comb begin
    r = {p, q[WIDTH-1]};
    ge = r >= {1'b0, d};
    p_n = op_q == ALU_MUL ? (p << 1) + (q[WIDTH-1] ? d : '0)
        : ge ? WIDTH'(r - {1'b0, d}) : r[WIDTH-1:0];
    q_n = op_q == ALU_MUL ? q << 1 : {q[WIDTH-2:0], ge};
  end
  assign done = busy && cnt == '0;
  assign result = op_q == ALU_DIVU ? q_n : p_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      op_q <= '0;
      p <= '0;
      q <= '0;
      d <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= SHW'(WIDTH - 1);
      op_q <= op;
      p <= '0;
      q <= op == ALU_MUL ? b : a;
      d <= op == ALU_MUL ? a : b;
    end else if (busy) begin
      p <= p_n;
      q <= q_n;
      cnt <= cnt - 1'b1;
      busy <= cnt != '0;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered EX-stage ALU with valid/ready handshakes and an iterative MUL/DIVU/REMU unit.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_d;
  logic accept, start, load, m_busy, m_done, ovf;
  logic [WIDTH-1:0] sum, diff, res, m_res, nxt;
  logic [SHW-1:0] sh;
  assign in_ready = state == IDLE && !m_busy && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign start = accept && is_iterative(aluctl);
  assign load = (accept && !is_iterative(aluctl)) || m_done;
  assign nxt = m_done ? m_res : res;
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (start ? BUSY : IDLE) : (m_done ? IDLE : BUSY);
  end
  always_comb begin
    sh = b[SHW-1:0];
    sum = a + b;
    diff = a - b;
    ovf = aluctl == ALU_ADD ? a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]
        : aluctl == ALU_SUB ? a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1] : 1'b0;
    res = '0;
    case (aluctl)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = sum;
      ALU_SLL:  res = a << sh;
      ALU_SRL:  res = a >> sh;
      ALU_SRA:  res = WIDTH'($signed(a) >>> sh);
      ALU_SUB:  res = diff;
      ALU_SLTU: res = WIDTH'(a < b);
      ALU_EQ:   res = WIDTH'(a == b);
      ALU_SLT:  res = WIDTH'($signed(a) < $signed(b));
      ALU_XOR:  res = a ^ b;
      default:  res = '0;
    endcase
  end
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk), .rst_n(rst_n), .start(start), .op(aluctl), .a(a), .b(b),
    .busy(m_busy), .done(m_done), .result(m_res)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out <= '0;
      zero <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      out_valid <= load || (out_valid && !out_ready);
      if (load) begin
        out <= nxt;
        zero <= nxt == '0;
        overflow <= !m_done && ovf;
      end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against a behavioural queue model.
module tb_alu_pipe;
  localparam int W = 32;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, zero, overflow;
  logic [3:0] aluctl = 0;
  logic [W-1:0] a = 0, b = 0, out;
  int checks = 0, errors = 0, cyc = 0, pops = 0, busy_end = 0;
  typedef struct {logic [W-1:0] val; logic ovf; int due;} exp_t;
  exp_t q[$];
  bit seen = 0, held = 0;
  logic [W-1:0] hv;
  logic hz, ho;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .aluctl(aluctl),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_iter(input logic [3:0] op);
    return op == 10 || op == 11 || op == 13;
  endfunction

  // returns {overflow, value}
  function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx = $signed(x), sy = $signed(y), t = 0, lim = longint'(1) << (W - 1);
    logic [63:0] pr;
    logic [W-1:0] v = '0;
    logic o = 0;
    int s = int'(y[4:0]);
    case (op)
      0: v = x & y;
      1: v = x | y;
      2: begin t = sx + sy; v = x + y; o = t >= lim || t < -lim; end
      3: v = x << s;
      4: v = x >> s;
      5: v = W'($signed(x) >>> s);
      6: begin t = sx - sy; v = x - y; o = t >= lim || t < -lim; end
      7: v = W'(x < y);
      8: v = W'(x == y);
      9: v = W'(sx < sy);
      10: begin pr = 64'(x) * 64'(y); v = pr[W-1:0]; end
      11: v = y == 0 ? '1 : x / y;
      12: v = x ^ y;
      13: v = y == 0 ? x : x % y;
      default: v = '0;
    endcase
    return {o, v};
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Compare process: expected results queue, timing, ready, and hold stability.
  always @(negedge clk) begin
    logic [W:0] m;
    cyc++;
    if (!rst_n) begin
      q.delete();
      busy_end = 0;
      seen = 0;
      held = 0;
    end else begin
      chk("in_ready", in_ready, cyc >= busy_end && (!out_valid || out_ready));
      if (held) begin
        chk("hold_out", out, hv);
        chk("hold_flags", {zero, overflow}, {hz, ho});
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          if (!seen) chk("latency", cyc, q[0].due);
          seen = 1;
          if (out_ready) begin
            chk("res_val", out, q[0].val);
            chk("res_ovf", overflow, q[0].ovf);
            chk("res_zero", zero, q[0].val == 0);
            void'(q.pop_front());
            seen = 0;
            pops++;
          end
        end
      end
      held = out_valid && !out_ready;
      hv = out;
      hz = zero;
      ho = overflow;
      if (in_valid && in_ready) begin
        m = model(aluctl, a, b);
        q.push_back('{m[W-1:0], m[W], cyc + (is_iter(aluctl) ? W + 1 : 1)});
        if (is_iter(aluctl)) busy_end = cyc + W + 1;
      end
    end
  end

  task automatic run(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] e, input logic eo, input int lat, input string nm);
    bit ok = 0;
    int k = 0;
    @(posedge clk); #1;
    in_valid = 1; aluctl = op; a = x; b = y; out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk({nm, "_accept"}, ok, 1);
    @(posedge clk); #1;
    in_valid = 0;
    ok = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; k = i; break; end
    end
    chk({nm, "_valid"}, ok, 1);
    chk({nm, "_lat"}, k, lat);
    chk({nm, "_out"}, out, e);
    chk({nm, "_ovf"}, overflow, eo);
    chk({nm, "_zero"}, zero, e == 0);
  endtask

  initial begin
    int p0;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    run(2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 1, "add_ovf");
    run(6, 32'h5, 32'h5, 32'h0, 0, 1, "sub_zero");
    run(6, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 1, "sub_ovf");
    run(5, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1, "sra");
    run(9, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1, "slt");
    run(7, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, "sltu");
    run(8, 32'h7, 32'h7, 32'h1, 0, 1, "eq");
    run(15, 32'h3, 32'h4, 32'h0, 0, 1, "op15");
    run(10, 32'h1_0000, 32'h1_0001, 32'h1_0000, 0, 33, "mul");
    run(11, 32'd100, 32'd7, 32'd14, 0, 33, "divu");
    run(13, 32'd100, 32'd7, 32'd2, 0, 33, "remu");
    run(11, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 0, 33, "divu0");
    run(13, 32'd9, 32'h0, 32'd9, 0, 33, "remu0");
    // backpressure: three ADDs against a stalled consumer
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; aluctl = 2; a = 1; b = 2;
    @(negedge clk) chk("bp_first_ready", in_ready, 1);
    @(posedge clk); #1 a = 3; b = 4;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_out", out, 3);
    end
    p0 = pops;
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk) chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1 a = 5; b = 6;
    @(negedge clk) chk("bp_third_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(negedge clk);
    chk("bp_count", pops - p0, 3);
    // reset in the middle of a divide
    @(posedge clk); #1;
    in_valid = 1; aluctl = 11; a = 1000; b = 3;
    @(negedge clk) chk("rdiv_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rdiv_valid", out_valid, 0);
    chk("rdiv_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    repeat (40) @(negedge clk);
    chk("rdiv_no_result", out_valid, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      aluctl = 4'($urandom_range(0, 15));
      a = rnd();
      b = rnd();
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    repeat (40) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
